// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stall/flush steering for DCache misses, branch
// mispredicts, multi-cycle divides and load-use hazards.
module pipeline_ctrl #(
    parameter int unsigned DIV_LATENCY = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ID_EX0_stall_from_DCache,
    input  logic       ID_EX0_flush_from_EX_Branch,
    input  logic       div_issue,
    input  logic       ex0_is_load,
    input  logic [4:0] ex0_rd,
    input  logic [4:0] id_rj,
    input  logic [4:0] id_rk,
    input  logic       id_rj_valid,
    input  logic       id_rk_valid,
    output logic       pc_stall,
    output logic       IF_ID_stall,
    output logic       ID_EX0_stall,
    output logic       EX0_EX1_stall,
    output logic       EX1_WB_stall,
    output logic       IF_ID_flush,
    output logic       ID_EX0_flush,
    output logic       EX0_EX1_flush,
    output logic       div_busy
);

    localparam int unsigned CNT_W = 6;

    typedef enum logic {RUN, DIV_WAIT} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               flush_pend_q;

    logic               dstall;
    logic               flush_any;
    logic               load_use;

    assign dstall    = ID_EX0_stall_from_DCache;
    assign flush_any = ID_EX0_flush_from_EX_Branch | flush_pend_q;
    assign load_use  = ex0_is_load && (ex0_rd != 5'd0) &&
                       ((id_rj_valid && (id_rj == ex0_rd)) ||
                        (id_rk_valid && (id_rk == ex0_rd)));

    // A branch seen under a DCache freeze is remembered and applied once the freeze lifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else if (dstall) begin
            if (ID_EX0_flush_from_EX_Branch)
                flush_pend_q <= 1'b1;
        end else if (flush_any) begin
            flush_pend_q <= 1'b0;
            state_q      <= RUN;
            cnt_q        <= '0;
        end else if (state_q == DIV_WAIT) begin
            if (cnt_q == '0)
                state_q <= RUN;
            else
                cnt_q <= cnt_q - CNT_W'(1);
        end else if (div_issue) begin
            state_q <= DIV_WAIT;
            cnt_q   <= CNT_W'(DIV_LATENCY - 1);
        end
    end

    always_comb begin
        pc_stall      = 1'b0;
        IF_ID_stall   = 1'b0;
        ID_EX0_stall  = 1'b0;
        EX0_EX1_stall = 1'b0;
        EX1_WB_stall  = 1'b0;
        IF_ID_flush   = 1'b0;
        ID_EX0_flush  = 1'b0;
        EX0_EX1_flush = 1'b0;
        div_busy      = 1'b0;
        if (rst) begin
            IF_ID_flush   = 1'b1;
            ID_EX0_flush  = 1'b1;
            EX0_EX1_flush = 1'b1;
        end else begin
            div_busy = (state_q == DIV_WAIT);
            if (dstall) begin
                pc_stall      = 1'b1;
                IF_ID_stall   = 1'b1;
                ID_EX0_stall  = 1'b1;
                EX0_EX1_stall = 1'b1;
                EX1_WB_stall  = 1'b1;
            end else if (flush_any) begin
                IF_ID_flush  = 1'b1;
                ID_EX0_flush = 1'b1;
            end else if (state_q == DIV_WAIT) begin
                pc_stall      = 1'b1;
                IF_ID_stall   = 1'b1;
                ID_EX0_stall  = 1'b1;
                EX0_EX1_flush = 1'b1;
            end else if (load_use) begin
                pc_stall     = 1'b1;
                IF_ID_stall  = 1'b1;
                ID_EX0_flush = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed hazard scenarios followed by
// random traffic, predicted by a cycle-count reference model.
module tb_pipeline_ctrl;

    localparam int unsigned DIV_LAT = 4;

    // Expected-vector bit positions
    localparam int B_PC   = 8;
    localparam int B_SIF  = 7;
    localparam int B_SID  = 6;
    localparam int B_SEX  = 5;
    localparam int B_SWB  = 4;
    localparam int B_FIF  = 3;
    localparam int B_FID  = 2;
    localparam int B_FEX  = 1;
    localparam int B_BUSY = 0;

    logic       clk;
    logic       rst;
    logic       dst;
    logic       br;
    logic       div;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rj;
    logic [4:0] rk;
    logic       rjv;
    logic       rkv;

    logic pc_stall, IF_ID_stall, ID_EX0_stall, EX0_EX1_stall, EX1_WB_stall;
    logic IF_ID_flush, ID_EX0_flush, EX0_EX1_flush, div_busy;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [8:0] exp_q[$];

    // Reference model state: busy cycles left in the divide, pending branch flush
    int unsigned div_left = 0;
    bit          pend     = 1'b0;

    pipeline_ctrl #(.DIV_LATENCY(DIV_LAT)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .ID_EX0_stall_from_DCache    (dst),
        .ID_EX0_flush_from_EX_Branch (br),
        .div_issue                   (div),
        .ex0_is_load                 (ld),
        .ex0_rd                      (rd),
        .id_rj                       (rj),
        .id_rk                       (rk),
        .id_rj_valid                 (rjv),
        .id_rk_valid                 (rkv),
        .pc_stall                    (pc_stall),
        .IF_ID_stall                 (IF_ID_stall),
        .ID_EX0_stall                (ID_EX0_stall),
        .EX0_EX1_stall               (EX0_EX1_stall),
        .EX1_WB_stall                (EX1_WB_stall),
        .IF_ID_flush                 (IF_ID_flush),
        .ID_EX0_flush                (ID_EX0_flush),
        .EX0_EX1_flush               (EX0_EX1_flush),
        .div_busy                    (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Predict this cycle's outputs from the current inputs, then advance the model
    task automatic predict();
        logic [8:0] e;
        bit busy;
        bit lu;
        e    = '0;
        busy = (div_left != 0);
        lu   = ld && (rd != 5'd0) && ((rjv && rj == rd) || (rkv && rk == rd));
        if (rst) begin
            e[B_FIF] = 1'b1; e[B_FID] = 1'b1; e[B_FEX] = 1'b1;
            div_left = 0;
            pend     = 1'b0;
        end else if (dst) begin
            e[B_PC] = 1'b1; e[B_SIF] = 1'b1; e[B_SID] = 1'b1;
            e[B_SEX] = 1'b1; e[B_SWB] = 1'b1;
            e[B_BUSY] = busy;
            if (br) pend = 1'b1;
        end else if (br || pend) begin
            e[B_FIF] = 1'b1; e[B_FID] = 1'b1;
            e[B_BUSY] = busy;
            pend     = 1'b0;
            div_left = 0;
        end else if (busy) begin
            e[B_PC] = 1'b1; e[B_SIF] = 1'b1; e[B_SID] = 1'b1;
            e[B_FEX] = 1'b1; e[B_BUSY] = 1'b1;
            div_left = div_left - 1;
        end else begin
            if (lu) begin
                e[B_PC] = 1'b1; e[B_SIF] = 1'b1; e[B_FID] = 1'b1;
            end
            if (div) div_left = DIV_LAT;
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic d, input logic b, input logic dv,
                       input logic l, input logic [4:0] rd_i, input logic [4:0] rj_i,
                       input logic [4:0] rk_i, input logic rjv_i, input logic rkv_i);
        @(posedge clk);
        #1;
        rst = r; dst = d; br = b; div = dv; ld = l;
        rd = rd_i; rj = rj_i; rk = rk_i; rjv = rjv_i; rkv = rkv_i;
        predict();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    // Monitor: compare every presented output vector against the scoreboard head
    always @(negedge clk) begin
        logic [8:0] act;
        logic [8:0] e;
        cycle++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {pc_stall, IF_ID_stall, ID_EX0_stall, EX0_EX1_stall, EX1_WB_stall,
                   IF_ID_flush, ID_EX0_flush, EX0_EX1_flush, div_busy};
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL outputs cycle=%0d got=%09b want=%09b (pc,sIF,sID,sEX,sWB,fIF,fID,fEX,busy)",
                         cycle, act, e);
            end
            checks++;
            if ((IF_ID_stall && IF_ID_flush) || (ID_EX0_stall && ID_EX0_flush) ||
                (EX0_EX1_stall && EX0_EX1_flush)) begin
                failures++;
                $display("FAIL stall_flush_excl cycle=%0d got=%09b want=no register both stalled and flushed",
                         cycle, act);
            end
        end
    end

    initial begin
        rst = 1'b1; dst = 1'b0; br = 1'b0; div = 1'b0; ld = 1'b0;
        rd = '0; rj = '0; rk = '0; rjv = 1'b0; rkv = 1'b0;

        cyc(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        cyc(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(2);

        // Load-use hit, then same pattern with r0 destination
        cyc(0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        cyc(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0);
        cyc(0, 0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 0, 1);
        cyc(0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd9, 0, 0);
        idle(1);

        // Plain divide, then divide with a 3-cycle DCache stall inside
        cyc(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(6);
        cyc(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        cyc(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(5);

        // Branch pulse inside a 5-cycle DCache stall is deferred
        for (int i = 0; i < 5; i++) cyc(0, 1, (i == 1), 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(2);

        // Branch beats load-use; branch aborts a divide
        cyc(0, 0, 1, 0, 1, 5'd7, 5'd7, 5'd0, 1, 0);
        cyc(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(1);
        cyc(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(2);

        // Reset mid-divide with a pending flush also in flight
        cyc(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        cyc(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(1);
        cyc(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(3);

        // Random traffic; divides only issued without a load in EX0
        for (int n = 0; n < 3000; n++) begin
            logic r_, d_, b_, dv_, l_;
            r_  = ($urandom_range(63) == 0);
            d_  = ($urandom_range(4) == 0);
            b_  = ($urandom_range(7) == 0);
            l_  = ($urandom_range(2) == 0);
            dv_ = !l_ && ($urandom_range(9) == 0);
            cyc(r_, d_, b_, dv_, l_, 5'($urandom_range(7)), 5'($urandom_range(7)),
                5'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        idle(1);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
